// File: rtl/bcd_display_formatter.sv
// Binary-to-BCD display formatter: converts a 27-bit value into 8 packed BCD digits
// by sequential double-dabble, saturating to SAT_CODE above 99_999_999.
module bcd_display_formatter #(
    parameter logic [31:0] SAT_CODE = 32'hEEEE_EEEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [26:0] bin_in,
    input  logic [7:0]  dp_in,
    output logic [31:0] display_data,
    output logic [7:0]  dot_point,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam logic [26:0] MaxInRange = 27'd99_999_999;
    localparam logic [4:0]  LastIter   = 5'd26;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_t;

    state_t      state_q;
    logic [26:0] shift_q;
    logic [31:0] acc_q;
    logic [4:0]  cnt_q;
    logic [7:0]  dp_q;
    logic        ovf_pending_q;

    logic [31:0] acc_adj;
    logic [31:0] acc_next;
    logic [26:0] shift_next;

    // Nibble-local add-3: a digit <= 4 cannot exceed 9 after doubling, so no carries.
    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < 8; i++) begin
            acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                           : acc_q[4*i +: 4];
        end
        acc_next   = {acc_adj[30:0], shift_q[26]};
        shift_next = {shift_q[25:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            dp_q          <= '0;
            ovf_pending_q <= 1'b0;
            display_data  <= '0;
            dot_point     <= '0;
            overflow      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        shift_q       <= bin_in;
                        dp_q          <= dp_in;
                        ovf_pending_q <= (bin_in > MaxInRange);
                        acc_q         <= '0;
                        cnt_q         <= '0;
                        state_q       <= StConv;
                    end
                end
                StConv: begin
                    acc_q   <= acc_next;
                    shift_q <= shift_next;
                    if (cnt_q == LastIter) begin
                        display_data <= ovf_pending_q ? SAT_CODE : acc_next;
                        dot_point    <= dp_q;
                        overflow     <= ovf_pending_q;
                        state_q      <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q == StConv);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Scoreboard bench for bcd_display_formatter: a driver queues expected results from a
// decimal reference model, a negedge monitor pops and compares on every done pulse.
module tb_bcd_display_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [26:0] bin_in = '0;
    logic [7:0]  dp_in = '0;
    logic [31:0] display_data;
    logic [7:0]  dot_point;
    logic        busy;
    logic        done;
    logic        overflow;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    exp_t hold;
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

    bcd_display_formatter dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bin_in       (bin_in),
        .dp_in        (dp_in),
        .display_data (display_data),
        .dot_point    (dot_point),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, saturating above eight digits.
    function automatic exp_t model(input int unsigned v, input logic [7:0] dp);
        exp_t e;
        int unsigned x;
        e.dp = dp;
        if (v > 99_999_999) begin
            e.data = 32'hEEEE_EEEE;
            e.ovf  = 1'b1;
        end else begin
            x = v;
            e.data = '0;
            for (int i = 0; i < 8; i++) begin
                e.data[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_done", {31'b0, done}, 32'd0);
            chk("rst_data", display_data, 32'd0);
            chk("rst_dp", {24'b0, dot_point}, 32'd0);
            chk("rst_ovf", {31'b0, overflow}, 32'd0);
        end else if (done) begin
            chk("done_width", {31'b0, prev_done}, 32'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                hold = q.pop_front();
                chk("data", display_data, hold.data);
                chk("dot_point", {24'b0, dot_point}, {24'b0, hold.dp});
                chk("overflow", {31'b0, overflow}, {31'b0, hold.ovf});
            end
            chk("busy_in_done", {31'b0, busy}, 32'd0);
        end else begin
            chk("hold_data", display_data, hold.data);
            chk("hold_dp", {24'b0, dot_point}, {24'b0, hold.dp});
            chk("hold_ovf", {31'b0, overflow}, {31'b0, hold.ovf});
        end
        prev_done = done;
    end

    // mode 0: plain; 1: extra start + new bin_in at E10; 2: reset at E15 (abort)
    task automatic convert(input int unsigned v, input logic [7:0] dp, input int mode);
        int  n;
        int  k;
        bit  got;
        k = 0;
        @(negedge clk);
        while ((busy || done) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=%0d required=<40", k);
        end
        start  = 1'b1;
        bin_in = 27'(v);
        dp_in  = dp;
        q.push_back(model(v, dp));
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 27'($urandom);
        dp_in  = 8'($urandom);
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        n = 1;
        got = 0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1;
            end else begin
                chk("busy_during_conv", {31'b0, busy}, 32'd1);
                if (mode == 1 && n == 10) begin
                    start  = 1'b1;
                    bin_in = 27'($urandom);
                end
                if (mode == 1 && n == 11) start = 1'b0;
                if (mode == 2 && n == 15) begin
                    #2;
                    rst = 1'b1;
                    q.delete();
                    hold = '{data: 32'd0, dp: 8'd0, ovf: 1'b0};
                    @(negedge clk);
                    #2;
                    rst = 1'b0;
                    n = 100;
                end
            end
        end
        if (mode == 2) begin
            repeat (35) @(negedge clk);
        end else begin
            chk("latency", n, 32'd28);
        end
    endtask

    initial begin
        int dones[$];
        int v;
        hold = '{data: 32'd0, dp: 8'd0, ovf: 1'b0};
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;

        convert(12_345_678, 8'h04, 0);
        convert(0, 8'h00, 0);
        convert(99_999_999, 8'hFF, 0);
        convert(100_000_000, 8'h81, 0);
        convert(7, 8'h01, 0);
        convert(134_217_727, 8'h10, 0);
        convert(42, 8'h00, 1);
        convert(55_555_555, 8'h22, 2);
        convert(1234, 8'h02, 0);

        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 134_217_727));
                1:       v = int'($urandom_range(0, 99_999_999));
                2:       v = int'($urandom_range(99_999_990, 100_000_010));
                default: v = int'($urandom_range(0, 200));
            endcase
            convert(v, 8'($urandom), 0);
        end

        // Held start: accepts every 29 cycles, four acceptances within 100 edges.
        @(negedge clk);
        while (busy || done) @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd5;
        dp_in  = 8'h00;
        repeat (4) q.push_back(model(5, 8'h00));
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            if (done) dones.push_back(i);
            if (i == 99) start = 1'b0;
        end
        chk("held_done_count", dones.size(), 32'd4);
        for (int i = 1; i < dones.size(); i++) begin
            chk("held_spacing", dones[i] - dones[i-1], 32'd29);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
